// File: rtl/ahb_arb_pkg.sv
// Shared types and helpers for the round-robin AHB bus arbiter.
// Holds the AHB transfer-type encoding, the arbiter FSM states and the one-hot grant helper.
package ahb_arb_pkg;

    localparam int MAX_MASTERS = 16;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        BUSY   = 2'd1,
        NONSEQ = 2'd2,
        SEQ    = 2'd3
    } trans_e;

    typedef enum logic [1:0] {
        PARK   = 2'd0,
        OWN    = 2'd1,
        LOCKED = 2'd2
    } arb_state_e;

    function automatic logic [MAX_MASTERS-1:0] onehot(input logic [3:0] idx);
        onehot = {{(MAX_MASTERS-1){1'b0}}, 1'b1} << idx;
    endfunction

endpackage

// File: rtl/ahb_arbiter_rr_pick.sv
// Rotate-priority encoder: first requester strictly after `last`, wrapping back to `last` itself.
module rr_pick #(
    parameter  int NMASTER = 4,
    localparam int IDX_W   = $clog2(NMASTER)
) (
    input  logic [NMASTER-1:0] req,
    input  logic [IDX_W-1:0]   last,
    output logic [IDX_W-1:0]   winner,
    output logic               any_req
);

    logic found_s;
    int   idx_s;

    // Scan last+1 .. last+NMASTER (mod NMASTER); the final step revisits last itself.
    always_comb begin
        winner  = last;
        found_s = 1'b0;
        idx_s   = 0;
        for (int i = 1; i <= NMASTER; i++) begin
            idx_s = (int'(last) + i) % NMASTER;
            if (!found_s && req[idx_s]) begin
                winner  = IDX_W'(idx_s);
                found_s = 1'b1;
            end else begin
                found_s = found_s;
            end
        end
        any_req = |req;
    end

endmodule

// File: rtl/ahb_arbiter.sv
// Round-robin AHB arbiter with HREADY-gated handover and locked-transfer support.
// Optional tenure limit for contended SEQ bursts is enabled by defining AHB_ARB_TIMEOUT_EN.
module ahb_arbiter
    import ahb_arb_pkg::*;
#(
    parameter  int NMASTER        = 4,
    parameter  int DEFAULT_MASTER = 0,
    parameter  int MAX_TENURE     = 16,
    localparam int IDX_W          = $clog2(NMASTER)
) (
    input  logic               HCLK,
    input  logic               HRESET,
    input  logic [NMASTER-1:0] HBUSREQ,
    input  logic [NMASTER-1:0] HLOCK,
    input  logic               HREADY,
    input  logic [1:0]         HTRANS,
    output logic [NMASTER-1:0] HGRANT,
    output logic [IDX_W-1:0]   HMASTER,
    output logic               HMASTLOCK
);

    if (NMASTER < 2 || NMASTER > MAX_MASTERS || DEFAULT_MASTER >= NMASTER || MAX_TENURE < 1) begin : g_bad_cfg
        $error("ahb_arbiter: parameter out of range");
    end

    arb_state_e         state_r;
    arb_state_e         next_state_s;
    logic [IDX_W-1:0]   owner_r;
    logic [IDX_W-1:0]   next_owner_s;
    logic [IDX_W-1:0]   winner_s;
    logic               any_req_s;
    logic               hold_s;
    logic               rearb_s;
    logic               expired_s;
    logic [NMASTER-1:0] hgrant_r;
    logic [IDX_W-1:0]   hmaster_r;
    logic               hmastlock_r;

    rr_pick #(.NMASTER(NMASTER)) u_rr_pick (
        .req     (HBUSREQ),
        .last    (owner_r),
        .winner  (winner_s),
        .any_req (any_req_s)
    );

`ifdef AHB_ARB_TIMEOUT_EN
    localparam int TEN_W = $clog2(MAX_TENURE + 1);

    logic [TEN_W-1:0] tenure_r;
    logic             others_req_s;

    assign others_req_s = |(HBUSREQ & ~NMASTER'(onehot(4'(owner_r))));
    assign expired_s    = (tenure_r == TEN_W'(MAX_TENURE));

    // Tenure counter: counts contended HREADY cycles of an unlocked owner, cleared on handover.
    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            tenure_r <= {TEN_W{1'b0}};
        end else if (HREADY) begin
            if ((next_owner_s != owner_r) || !others_req_s) begin
                tenure_r <= {TEN_W{1'b0}};
            end else if (state_r == OWN) begin
                tenure_r <= tenure_r + {{(TEN_W-1){1'b0}}, 1'b1};
            end else begin
                tenure_r <= tenure_r;
            end
        end else begin
            tenure_r <= tenure_r;
        end
    end
`else
    assign expired_s = 1'b0;
`endif

    // Next owner/state: a live lock blocks handover; otherwise rearbitrate on idle, drop or expiry.
    always_comb begin
        hold_s       = (state_r == LOCKED) && HLOCK[owner_r] && HBUSREQ[owner_r];
        rearb_s      = !hold_s && (!HBUSREQ[owner_r] || (trans_e'(HTRANS) != SEQ) || expired_s);
        next_owner_s = owner_r;
        next_state_s = state_r;
        if (rearb_s && !any_req_s) begin
            next_owner_s = IDX_W'(DEFAULT_MASTER);
            next_state_s = PARK;
        end else begin
            if (rearb_s) begin
                next_owner_s = winner_s;
            end else begin
                next_owner_s = owner_r;
            end
            if (HLOCK[next_owner_s]) begin
                next_state_s = LOCKED;
            end else begin
                next_state_s = OWN;
            end
        end
    end

    // State and output registers; HREADY low freezes everything, reset overrides HREADY.
    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            state_r     <= PARK;
            owner_r     <= IDX_W'(DEFAULT_MASTER);
            hgrant_r    <= NMASTER'(onehot(4'(DEFAULT_MASTER)));
            hmaster_r   <= IDX_W'(DEFAULT_MASTER);
            hmastlock_r <= 1'b0;
        end else if (HREADY) begin
            state_r     <= next_state_s;
            owner_r     <= next_owner_s;
            hgrant_r    <= NMASTER'(onehot(4'(next_owner_s)));
            hmaster_r   <= owner_r;
            hmastlock_r <= (state_r == LOCKED);
        end else begin
            state_r     <= state_r;
            owner_r     <= owner_r;
            hgrant_r    <= hgrant_r;
            hmaster_r   <= hmaster_r;
            hmastlock_r <= hmastlock_r;
        end
    end

    assign HGRANT    = hgrant_r;
    assign HMASTER   = hmaster_r;
    assign HMASTLOCK = hmastlock_r;

endmodule

// File: tb/tb_ahb_arbiter.sv
// Directed scoreboard bench for ahb_arbiter (NMASTER=4, DEFAULT_MASTER=0, MAX_TENURE=16).
// Stimulus pushes hand-computed post-edge expectations; a monitor pops and compares after each edge.
module tb_ahb_arbiter;

    localparam logic [1:0] T_IDLE   = 2'd0;
    localparam logic [1:0] T_NONSEQ = 2'd2;
    localparam logic [1:0] T_SEQ    = 2'd3;

    logic       HCLK;
    logic       HRESET;
    logic [3:0] HBUSREQ;
    logic [3:0] HLOCK;
    logic       HREADY;
    logic [1:0] HTRANS;
    logic [3:0] HGRANT;
    logic [1:0] HMASTER;
    logic       HMASTLOCK;

    typedef struct packed {
        logic [3:0] g;
        logic [1:0] m;
        logic       l;
    } exp_t;

    exp_t  exp_q[$];
    string name_q[$];
    exp_t  e;
    string nm;
    int    n_cmp  = 0;
    int    n_fail = 0;

    ahb_arbiter #(.NMASTER(4), .DEFAULT_MASTER(0), .MAX_TENURE(16)) dut (
        .HCLK      (HCLK),
        .HRESET    (HRESET),
        .HBUSREQ   (HBUSREQ),
        .HLOCK     (HLOCK),
        .HREADY    (HREADY),
        .HTRANS    (HTRANS),
        .HGRANT    (HGRANT),
        .HMASTER   (HMASTER),
        .HMASTLOCK (HMASTLOCK)
    );

    initial begin
        HCLK = 1'b0;
        forever #5 HCLK = ~HCLK;
    end

    // Drive one cycle of inputs at the falling edge and queue the state expected after the next rising edge.
    task automatic cyc(input logic rst, input logic rdy, input logic [3:0] req, input logic [3:0] lock,
                       input logic [1:0] trans, input logic chk, input logic [3:0] g, input logic [1:0] m,
                       input logic l, input string name);
        exp_t x;
        @(negedge HCLK);
        HRESET  = rst;
        HREADY  = rdy;
        HBUSREQ = req;
        HLOCK   = lock;
        HTRANS  = trans;
        if (chk) begin
            x.g = g;
            x.m = m;
            x.l = l;
            exp_q.push_back(x);
            name_q.push_back(name);
        end
    endtask

    // Monitor: compare the DUT outputs just after each rising edge against the queued expectation.
    always @(posedge HCLK) begin
        #1;
        if (exp_q.size() != 0) begin
            e  = exp_q.pop_front();
            nm = name_q.pop_front();
            n_cmp++;
            if (HGRANT !== e.g || HMASTER !== e.m || HMASTLOCK !== e.l) begin
                n_fail++;
                $display("FAIL %s: got HGRANT=%b HMASTER=%0d HMASTLOCK=%b, expected HGRANT=%b HMASTER=%0d HMASTLOCK=%b",
                         nm, HGRANT, HMASTER, HMASTLOCK, e.g, e.m, e.l);
            end
        end
    end

    initial begin
        HRESET  = 1'b1;
        HREADY  = 1'b1;
        HBUSREQ = 4'b0000;
        HLOCK   = 4'b0000;
        HTRANS  = T_IDLE;

        cyc(1'b1, 1'b1, 4'b0000, 4'b0000, T_IDLE, 1'b1, 4'b0001, 2'd0, 1'b0, "reset");
        repeat (5) cyc(1'b0, 1'b1, 4'b0000, 4'b0000, T_IDLE, 1'b1, 4'b0001, 2'd0, 1'b0, "park_idle");

        cyc(1'b0, 1'b1, 4'b0110, 4'b0000, T_NONSEQ, 1'b1, 4'b0010, 2'd0, 1'b0, "grant_m1");
        cyc(1'b0, 1'b1, 4'b0110, 4'b0000, T_SEQ,    1'b1, 4'b0010, 2'd1, 1'b0, "hmaster_m1");
        cyc(1'b0, 1'b1, 4'b0100, 4'b0000, T_IDLE,   1'b1, 4'b0100, 2'd1, 1'b0, "drop_m1");
        cyc(1'b0, 1'b1, 4'b0100, 4'b0000, T_SEQ,    1'b1, 4'b0100, 2'd2, 1'b0, "own_m2");

        repeat (3) cyc(1'b0, 1'b0, 4'b0000, 4'b0000, T_SEQ, 1'b1, 4'b0100, 2'd2, 1'b0, "wait_freeze");
        cyc(1'b0, 1'b1, 4'b0000, 4'b0000, T_IDLE, 1'b1, 4'b0001, 2'd2, 1'b0, "park_after_wait");
        cyc(1'b0, 1'b1, 4'b0000, 4'b0000, T_IDLE, 1'b1, 4'b0001, 2'd0, 1'b0, "park_hmaster");

        cyc(1'b0, 1'b1, 4'b1111, 4'b0000, T_NONSEQ, 1'b1, 4'b0010, 2'd0, 1'b0, "rr_1");
        cyc(1'b0, 1'b1, 4'b1111, 4'b0000, T_NONSEQ, 1'b1, 4'b0100, 2'd1, 1'b0, "rr_2");
        cyc(1'b0, 1'b1, 4'b1111, 4'b0000, T_NONSEQ, 1'b1, 4'b1000, 2'd2, 1'b0, "rr_3");
        cyc(1'b0, 1'b1, 4'b1111, 4'b0000, T_NONSEQ, 1'b1, 4'b0001, 2'd3, 1'b0, "rr_wrap");
        cyc(1'b0, 1'b1, 4'b0001, 4'b0000, T_SEQ,    1'b1, 4'b0001, 2'd0, 1'b0, "rr_self");
        cyc(1'b0, 1'b1, 4'b0000, 4'b0000, T_IDLE,   1'b1, 4'b0001, 2'd0, 1'b0, "rr_park");

        cyc(1'b0, 1'b1, 4'b1000, 4'b1000, T_NONSEQ, 1'b1, 4'b1000, 2'd0, 1'b0, "lock_grant");
        repeat (40) cyc(1'b0, 1'b1, 4'b1111, 4'b1000, T_NONSEQ, 1'b1, 4'b1000, 2'd3, 1'b1, "lock_hold");
        cyc(1'b0, 1'b1, 4'b1111, 4'b0000, T_NONSEQ, 1'b1, 4'b0001, 2'd3, 1'b1, "lock_release");
        cyc(1'b0, 1'b1, 4'b0000, 4'b0000, T_IDLE,   1'b1, 4'b0001, 2'd0, 1'b0, "lock_park");

        cyc(1'b0, 1'b1, 4'b0010, 4'b0000, T_NONSEQ, 1'b1, 4'b0010, 2'd0, 1'b0, "ten_grant");
`ifdef AHB_ARB_TIMEOUT_EN
        repeat (16) cyc(1'b0, 1'b1, 4'b0011, 4'b0000, T_SEQ, 1'b1, 4'b0010, 2'd1, 1'b0, "ten_hold");
        cyc(1'b0, 1'b1, 4'b0011, 4'b0000, T_SEQ, 1'b1, 4'b0001, 2'd1, 1'b0, "ten_expire");
        cyc(1'b0, 1'b1, 4'b0011, 4'b0000, T_SEQ, 1'b1, 4'b0001, 2'd0, 1'b0, "ten_new_owner");
`else
        repeat (40) cyc(1'b0, 1'b1, 4'b0011, 4'b0000, T_SEQ, 1'b1, 4'b0010, 2'd1, 1'b0, "seq_no_timeout");
`endif
        cyc(1'b0, 1'b1, 4'b0000, 4'b0000, T_IDLE, 1'b0, 4'b0001, 2'd0, 1'b0, "ten_leave");
        cyc(1'b0, 1'b1, 4'b0000, 4'b0000, T_IDLE, 1'b1, 4'b0001, 2'd0, 1'b0, "ten_park");

        cyc(1'b0, 1'b1, 4'b1000, 4'b0000, T_NONSEQ, 1'b1, 4'b1000, 2'd0, 1'b0, "burst_m3");
        cyc(1'b0, 1'b1, 4'b1000, 4'b0000, T_SEQ,    1'b1, 4'b1000, 2'd3, 1'b0, "burst_seq");
        cyc(1'b0, 1'b0, 4'b1000, 4'b0000, T_SEQ,    1'b1, 4'b1000, 2'd3, 1'b0, "burst_wait");
        cyc(1'b1, 1'b0, 4'b1000, 4'b0000, T_SEQ,    1'b1, 4'b0001, 2'd0, 1'b0, "reset_mid_burst");
        cyc(1'b0, 1'b1, 4'b0000, 4'b0000, T_IDLE,   1'b1, 4'b0001, 2'd0, 1'b0, "post_reset");

        for (int i = 0; i < 10 && exp_q.size() != 0; i++) begin
            @(negedge HCLK);
        end
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL drain: %0d expectations left unchecked, expected 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/ahb_arbiter.md
# ahb_arbiter

Round-robin AHB bus arbiter that shares the system bus between the NN bus-master command engine and the other bus masters. It consumes HBUSREQ/HLOCK from each master, drives the one-hot HGRANT vector and the registered HMASTER/HMASTLOCK that the address/data muxes and slaves use. Grant handover is gated by HREADY so a master never loses the bus mid-transfer, and an optional tenure limit keeps long LoadMem/SaveMem INCR bursts from starving the other masters.

## Interface
- NMASTER, 4, number of bus masters (2..16)
- DEFAULT_MASTER, 0, master parked on the bus when nobody requests
- MAX_TENURE, 16, HREADY cycles a contended owner may hold the bus (used only with the timeout feature)

- HCLK  in  1  bus clock; all state updates on rising edge
- HRESET  in  1  synchronous, active-high reset
- HBUSREQ  in  NMASTER  per-master bus request
- HLOCK  in  NMASTER  per-master locked-transfer request
- HREADY  in  1  bus-wide transfer-complete, from the slave mux
- HTRANS  in  2  transfer type of the current address-phase master (IDLE=0, BUSY=1, NONSEQ=2, SEQ=3)
- HGRANT  out  NMASTER  one-hot grant, registered
- HMASTER  out  clog2(NMASTER)  index of the address-phase owner, registered
- HMASTLOCK  out  1  current address phase is locked, registered

## Operation
- Internal `owner` register; HGRANT = one-hot(owner); exactly one bit is set at all times, including reset.
- States:
  - PARK: no requests; owner = DEFAULT_MASTER.
  - OWN: owner is requesting.
  - LOCKED: HLOCK[owner] and HBUSREQ[owner] are both high.
- Rearbitration happens only on a cycle with HREADY=1, in state != LOCKED, and when one of these holds:
  - HBUSREQ[owner]=0, or
  - HTRANS != SEQ, or
  - tenure expired (timeout feature only).
- Winner selection:
  - Scan owner+1, owner+2, … mod NMASTER and take the first master with HBUSREQ set.
  - If the scan finds only owner, keep owner.
  - If no master requests, park on DEFAULT_MASTER and go to PARK.
- LOCKED exits when HLOCK[owner] or HBUSREQ[owner] drops, evaluated at the next HREADY=1 cycle.
- HMASTER <= owner and HMASTLOCK <= (state==LOCKED) on every HREADY=1 cycle; both hold while HREADY=0.
- HREADY=0 freezes owner, state, HMASTER, HMASTLOCK and the tenure counter.

## Timing
- Reset values:
  - HGRANT = 1<<DEFAULT_MASTER
  - HMASTER = DEFAULT_MASTER
  - HMASTLOCK = 0
  - state = PARK
  - tenure = 0
- Latency:
  - HBUSREQ sampled at edge t; HGRANT changes at edge t+1 if the rearbitration condition holds at t.
  - HMASTER follows at the first edge with HREADY=1 after the grant changes (one cycle minimum).
- Simultaneous requests: round-robin order relative to the current owner; no fixed priority.
- An owner dropping HBUSREQ during HREADY=0 loses the bus at the first HREADY=1 edge.
- A new requester never preempts a locked owner.
- Reset mid-burst: all outputs return to reset values on the next edge, regardless of HREADY.

## Configuration
- Macro: AHB_ARB_TIMEOUT_EN.
- Defined:
  - A tenure counter (width clog2(MAX_TENURE+1)) increments on HREADY=1 while state==OWN and any other master requests.
  - Counter clears on a grant change or when no other master requests.
  - At count == MAX_TENURE the owner is rearbitrated even during SEQ.
  - LOCKED ignores the counter.
- Undefined: no counter exists; an owner issuing SEQ keeps the bus until HTRANS != SEQ or its request drops.

## Structure
- Package ahb_arb_pkg holds:
  - transfermode enum (IDLE, BUSY, NONSEQ, SEQ)
  - arbiter state enum (PARK, OWN, LOCKED)
  - helper function onehot(idx)
- Sub-module rr_pick (combinational rotate-priority encoder).
  - Inputs: req vector, last owner.
  - Outputs: winner index, any_req.
- ahb_arbiter holds the registers, FSM and tenure counter.

## Test plan
- Reset with no requests, NMASTER=4, DEFAULT_MASTER=0 -> HGRANT=4'b0001, HMASTER=0, HMASTLOCK=0 for 5 cycles.
- HBUSREQ=4'b0110 from PARK with HREADY=1 -> HGRANT=4'b0010 next cycle and HMASTER=1 the cycle after; drop req[1] -> HGRANT=4'b0100.
- Owner 2 issuing SEQ, HREADY held low 3 cycles while req[2] drops -> HGRANT frozen at 4'b0100 until the first HREADY=1 edge, then parks at 4'b0001.
- HLOCK[3]=1 with HBUSREQ=4'b1111 for 40 cycles -> HGRANT stays 4'b1000 and HMASTLOCK=1; release lock -> grant moves to master 0.
- AHB_ARB_TIMEOUT_EN, MAX_TENURE=16: master 1 issues continuous SEQ while req[0] is high -> grant moves to 0 after exactly 16 HREADY cycles. Without the macro -> grant never moves.
- Assert HRESET during owner 3's burst -> HGRANT=4'b0001 and HMASTER=0 on the next edge.
